// File: rtl/svm_pkg.sv
// Shared constants and FSM encoding for the SVM engine scheduler.
// Latency: none (definitions only).
// Backpressure: not applicable.
package svm_pkg;

  // Feature vector shape fixed by the svm_inference engine.
  localparam int NUM_FEAT = 7;
  localparam int FEAT_W   = 16;

  // Engine run time: one pass per support vector.
  localparam int CYC_PER_SV        = 22;
  localparam int NUM_SV            = 786;
  localparam int ENGINE_RUN_CYCLES = CYC_PER_SV * NUM_SV;

  // Watchdog headroom on top of a nominal run, rounding the default to 20000.
  localparam int TIMEOUT_MARGIN  = 2708;
  localparam int DEFAULT_TIMEOUT = ENGINE_RUN_CYCLES + TIMEOUT_MARGIN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] pos;

  assign any = |req;

  // Scan N positions starting at ptr; the first pending request wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    pos          = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found             = 1'b1;
        grant_onehot[pos] = 1'b1;
        grant_idx         = pos;
      end
    end
  end

endmodule

// File: rtl/svm_engine_scheduler.sv
// Shares one SVM engine among NUM_REQ requesters: round-robin accept, hold features, run, respond.
// Latency: accept -> eng_start next cycle -> engine run -> resp_valid one cycle after eng_done.
// Backpressure: req_ready is offered only in IDLE; a watchdog bounds every run and the drain after a timeout.
module svm_engine_scheduler
  import svm_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int NUM_FEAT       = svm_pkg::NUM_FEAT,
  parameter int FEAT_W         = svm_pkg::FEAT_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*NUM_FEAT*FEAT_W-1:0] req_features,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic                               resp_fall,
  output logic                               resp_timeout,
  output logic                               busy,
  output logic                               eng_start,
  output logic [NUM_FEAT*FEAT_W-1:0]         eng_features,
  input  logic                               eng_done,
  input  logic                               eng_fall
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int VEC_W = NUM_FEAT * FEAT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_q;
  logic [VEC_W-1:0] hold_q;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [VEC_W-1:0]   sel_vec;
  logic [NUM_REQ-1:0] grant_q_oh;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req          (req_valid),
    .ptr          (ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any          (arb_any)
  );

  // Accept strobe is only offered while idle; forced low while reset is asserted.
  assign req_ready = (reset_n && state == S_IDLE) ? arb_onehot : '0;

  // Engine sees only the hold register, never the live requester inputs.
  assign eng_features = hold_q;

  assign grant_q_oh = NUM_REQ'(1) << grant_q;

  // Mux the winning requester's feature vector for latching on accept.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_onehot[i]) sel_vec = req_features[i*VEC_W +: VEC_W];
    end
  end

  // Scheduler FSM with registered strobes, watchdog and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      grant_q      <= '0;
      hold_q       <= '0;
      cnt          <= '0;
      timeout_q    <= 1'b0;
      eng_start    <= 1'b0;
      resp_valid   <= '0;
      resp_fall    <= 1'b0;
      resp_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      eng_start    <= 1'b0;
      resp_valid   <= '0;
      resp_fall    <= 1'b0;
      resp_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            hold_q    <= sel_vec;
            grant_q   <= arb_idx;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (eng_done) begin
            resp_valid <= grant_q_oh;
            resp_fall  <= eng_fall;
            timeout_q  <= 1'b0;
            state      <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            resp_valid   <= grant_q_oh;
            resp_timeout <= 1'b1;
            timeout_q    <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          ptr <= (grant_q == IDX_LAST) ? '0 : grant_q + IDX_W'(1);
          cnt <= '0;
          if (timeout_q) begin
            state <= S_DRAIN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // A late done from the stalled run is swallowed here.
          cnt <= cnt + CNT_W'(1);
          if (eng_done || cnt == CNT_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
